// File: rtl/serial_to_parallel_pkg.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_pkg
//
// Purpose : Shared types for the serial_to_parallel deserializer.
//           Holds the output-side state encoding and a small helper used to
//           size the beat counter.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package serial_to_parallel_pkg;

  // Output register occupancy: EMPTY means no frame is presented,
  // FULL means parallel_o holds a complete, not yet drained frame.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a counter that holds 0 .. num_beats-1. Never returns 0 so the
  // counter stays a real signal even for the smallest legal frame size.
  function automatic int unsigned cnt_width(input int unsigned num_beats);
    return (num_beats > 2) ? $clog2(num_beats) : 1;
  endfunction

endpackage : serial_to_parallel_pkg

// File: rtl/serial_to_parallel_beat_counter.sv
// -----------------------------------------------------------------------------
// beat_counter
//
// Purpose : Mod-NUM_BEATS up-counter tracking how many beats of the current
//           frame are already held in the assembly buffer.
// Ports   :
//   clk_i   in  clock, rising edge
//   rst_ni  in  synchronous active-low reset (clears the count)
//   inc_i   in  advance by one, wrapping from NUM_BEATS-1 to 0
//   clr_i   in  force the count to 0 (wins over inc_i)
//   cnt_o   out current count
//   last_o  out cnt_o == NUM_BEATS-1
// -----------------------------------------------------------------------------
module beat_counter
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned CNT_W     = cnt_width(NUM_BEATS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_BEATS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LastCnt);

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      // Explicit wrap keeps the counter correct for non-power-of-two frames.
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = w_last;

endmodule : beat_counter

// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Purpose : Handshaked deserializer. Collects NUM_BEATS beats of DATA_WIDTH
//           bits into one frame and presents it on a valid/ready port.
//           The assembly buffer and the output register are separate, so the
//           next frame can assemble while the previous one waits; sustained
//           throughput is one beat per cycle.
// Ports   :
//   clk_i             in   clock, rising edge
//   rst_ni            in   synchronous active-low reset
//   serial_i          in   incoming beat
//   serial_valid_i    in   serial_i is valid
//   serial_ready_o    out  beat is accepted this cycle (if valid)
//   flush_i           in   discard the partially assembled frame
//   parallel_o        out  assembled frame, beat k in parallel_o[k]
//   parallel_valid_o  out  parallel_o holds a complete frame
//   parallel_ready_i  in   consumer takes the frame
//   beat_cnt_o        out  beats already held in the assembly buffer
// -----------------------------------------------------------------------------
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned NUM_BEATS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = cnt_width(NUM_BEATS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [DATA_WIDTH-1:0]                serial_i,
  input  logic                                 serial_valid_i,
  output logic                                 serial_ready_o,
  input  logic                                 flush_i,
  output logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] parallel_o,
  output logic                                 parallel_valid_o,
  input  logic                                 parallel_ready_i,
  output logic [CNT_W-1:0]                     beat_cnt_o
);

  localparam type data_t = logic [DATA_WIDTH-1:0];

  if (NUM_BEATS < 2) begin : g_param_check
    $error("serial_to_parallel: NUM_BEATS must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  data_t [NUM_BEATS-1:0] r_asm;        // assembly buffer
  data_t [NUM_BEATS-1:0] r_out;        // presented frame
  out_state_e            r_state;
  out_state_e            w_state_next;

  logic [CNT_W-1:0]      w_cnt;
  logic                  w_last;
  logic                  w_out_valid;
  logic                  w_serial_ready;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_frame_done;
  data_t [NUM_BEATS-1:0] w_frame;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign w_out_valid = (r_state == OUT_FULL);

  // Only the last beat can stall: it needs the output register, which is free
  // when empty or when the consumer drains it in this same cycle. The path
  // from parallel_ready_i to serial_ready_o is deliberate.
  assign w_serial_ready = rst_ni & ~flush_i &
                          (~w_last | ~w_out_valid | parallel_ready_i);

  assign w_accept     = serial_valid_i & w_serial_ready;
  assign w_drain      = w_out_valid & parallel_ready_i;
  assign w_frame_done = w_accept & w_last;

  // ---------------------------------------------------------------------------
  // Beat counter
  // ---------------------------------------------------------------------------
  beat_counter #(
    .NUM_BEATS (NUM_BEATS),
    .CNT_W     (CNT_W)
  ) u_beat_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_accept),
    .clr_i  (flush_i),
    .cnt_o  (w_cnt),
    .last_o (w_last)
  );

  // ---------------------------------------------------------------------------
  // Assembly buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is a plain register array, so it is reset explicitly to
  // give a defined all-zero state rather than relying on power-up contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_asm <= '0;
    end else if (w_accept) begin
      r_asm[w_cnt] <= serial_i;
    end
  end

  // The last beat goes straight into the output register, bypassing r_asm,
  // so a frame is presented in the cycle right after its last beat.
  always_comb begin
    // NOTE: every output of this block is assigned first so no path leaves
    // it unassigned, which would infer a latch.
    w_frame                = r_asm;
    w_frame[NUM_BEATS-1]   = serial_i;
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // On a drain without a new frame r_out keeps its stale contents; only the
  // valid flag clears.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else if (w_frame_done) begin
      r_out <= w_frame;
    end
  end

  // ---------------------------------------------------------------------------
  // Output occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      OUT_EMPTY: if (w_frame_done) w_state_next = OUT_FULL;
      // Drain together with a new frame keeps the register full.
      OUT_FULL:  if (w_drain && !w_frame_done) w_state_next = OUT_EMPTY;
      default:   w_state_next = OUT_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign serial_ready_o   = w_serial_ready;
  assign parallel_o       = r_out;
  assign parallel_valid_o = w_out_valid;
  assign beat_cnt_o       = w_cnt;

endmodule : serial_to_parallel

// File: doc/serial_to_parallel.md
# serial_to_parallel

Handshaked deserializer: collects `NUM_BEATS` serial data beats into one parallel frame and presents it on a valid/ready output port. It is the receive-side counterpart of `shift_reg`, which is parallel-in/serial-out, and sits between a serial link and wide datapath consumers. Assembly and output registers are double-buffered, so sustained throughput is one beat per cycle with no bubbles between frames.

## Interface
- `NUM_BEATS`, 4: beats per frame; legal values ≥ 2.
- `DATA_WIDTH`, 8: bits per beat.
- `data_t` (localparam type): `logic [DATA_WIDTH-1:0]`.
- `clk_i`  input  1: clock; all logic on rising edge. One clock only.
- `rst_ni`  input  1: reset, synchronous, active-low.
- `serial_i`  input  `DATA_WIDTH`: incoming beat.
- `serial_valid_i`  input  1: beat on `serial_i` is valid.
- `serial_ready_o`  output  1: block accepts a beat this cycle.
- `flush_i`  input  1: discard the partially assembled frame.
- `parallel_o`  output  `NUM_BEATS*DATA_WIDTH` (`data_t [NUM_BEATS-1:0]`): assembled frame.
- `parallel_valid_o`  output  1: `parallel_o` holds a complete frame.
- `parallel_ready_i`  input  1: consumer takes the frame.
- `beat_cnt_o`  output  `$clog2(NUM_BEATS)`: beats already held in the assembly buffer.

## Operation
- Beat accept: `serial_valid_i & serial_ready_o` at a rising edge.
- Frame drain: `parallel_valid_o & parallel_ready_i` at a rising edge.
- Assembly buffer `asm_q[NUM_BEATS-1:0]` and counter `cnt_q`.
  - Accepted beat number k of the frame (0-based) is written to `asm_q[k]`. The first beat therefore lands at index 0.
  - On a non-last beat, `cnt_q` increments.
  - On the last beat (`cnt_q == NUM_BEATS-1`), `cnt_q` wraps to 0 and the full frame, including the current `serial_i` in index `NUM_BEATS-1`, is copied into output register `out_q`. `out_valid_q` is set.
- `serial_ready_o = rst_ni & ~flush_i & ((cnt_q != NUM_BEATS-1) | ~out_valid_q | parallel_ready_i)`.
  - Non-last beats are never stalled.
  - The last beat stalls only while a previous frame is still un-drained.
  - There is a combinational path from `parallel_ready_i` to `serial_ready_o`. This is intentional.
- Output register `out_q` (drives `parallel_o`) and `out_valid_q` (drives `parallel_valid_o`):
  - Drain without a new frame: `out_valid_q` clears. `out_q` holds its stale value.
  - Drain and last-beat accept in the same cycle: `out_q` loads the new frame and `out_valid_q` stays 1.
  - While `parallel_valid_o=1` and not drained, `parallel_o` is stable.
- `flush_i=1`: `cnt_q` goes to 0 at the next edge and no beat is accepted that cycle. `asm_q` contents are don't-care. `out_q` and `out_valid_q` are unaffected; a drain in the same cycle still completes.
- `beat_cnt_o = cnt_q`.
- Output-side states: EMPTY (`out_valid_q=0`) and FULL (`out_valid_q=1`).
  - EMPTY → FULL on a last-beat accept.
  - FULL → EMPTY on a drain without a last-beat accept.
  - FULL → FULL on a drain together with a last-beat accept.

## Timing
- Reset (`rst_ni=0` sampled at an edge): `cnt_q=0`, `asm_q='0`, `out_q='0`, `out_valid_q=0`.
  - So after reset `parallel_o='0`, `parallel_valid_o=0`, `beat_cnt_o=0`.
  - `serial_ready_o=0` while `rst_ni=0`.
- Reset asserted mid-frame or with `parallel_valid_o=1`: all state is discarded at that edge and the frame is lost.
- Latency: last beat accepted at edge t → `parallel_valid_o=1` in the cycle following edge t.
- Throughput: with `serial_valid_i` and `parallel_ready_i` held high, one frame completes every `NUM_BEATS` cycles and `serial_ready_o` stays 1.
- Simultaneous `flush_i` and last-beat `serial_valid_i`: no beat is accepted and no frame is produced.

## Structure
- Self-contained. No shared package entry is needed; `data_t` is a local type.
- One natural sub-module: `beat_counter`, a mod-`NUM_BEATS` up-counter with increment, clear and synchronous reset, exposing `cnt` and `last` (`cnt == NUM_BEATS-1`).
- Elaboration-time check: `NUM_BEATS >= 2`.

## Test plan
All scenarios use `NUM_BEATS=4`, `DATA_WIDTH=8`.
- **Reset:** hold `rst_ni=0` for 2 cycles with `serial_valid_i=1` → `serial_ready_o=0`, `parallel_valid_o=0`, `parallel_o=0`, `beat_cnt_o=0`.
- **Single frame:** beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `parallel_ready_i=1` → one cycle after the 4th accept, `parallel_o[0..3]=11,22,33,44` and `parallel_valid_o=1` for exactly one cycle.
- **Back-to-back:** 8 continuous beats 0x01..0x08 → frames {01,02,03,04} then {05,06,07,08}, 4 cycles apart. `serial_ready_o` never drops.
- **Backpressure:** hold `parallel_ready_i=0` after frame 1 and stream frame 2 → beats 1-3 of frame 2 are accepted, then `serial_ready_o=0` on beat 4. `parallel_o` stays {01,02,03,04}. Releasing ready drains frame 1 and accepts beat 4 in the same cycle; frame 2 is presented on the next cycle.
- **Flush:** accept 0xAA, 0xBB, assert `flush_i` for one cycle, then send 0x01..0x04 → `beat_cnt_o` goes 2 → 0 and the output frame is {01,02,03,04}.
- **Reset mid-operation:** `parallel_valid_o=1` and `beat_cnt_o=2`, then one reset cycle → `parallel_valid_o=0` and `beat_cnt_o=0`. The next 4 beats form a clean frame.
